mod_updown_counter: RTL
=======================

Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down counter. Successor to the 4-bit ripple counter.
- Single clock domain, rising-edge only, no ripple clocking.
- Adds programmable modulus, enable prescaler, parallel load, direction control, wrap/one-shot mode and terminal-count/wrap/done flags.
- Used as a generic event/timebase counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count range 0..MODULUS-1. Legal values 2 <= MODULUS <= 2^WIDTH.
- PRESCALE, 1, number of enabled cycles per count step. Must be >= 1; 1 means a step on every enabled cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  count enable; advances the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement. Sampled at each tick.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- mode  in  1  0 = wrap (free-running), 1 = one-shot (stop at terminal).
- q  out  WIDTH  registered count.
- tc  out  1  combinational terminal-count: this cycle's tick hits the terminal value.
- wrap  out  1  registered one-cycle pulse after a terminal tick.
- done  out  1  registered; one-shot has reached its terminal and stopped.

Behaviour:
- Reset: reset is synchronous, active-high. At the clock edge where reset = 1: q = 0, prescaler = 0, wrap = 0, done = 0. Reset overrides all other inputs.
- Prescaler:
  - Internal counter pre of width max(1, clog2(PRESCALE)).
  - While en = 1 and done = 0, pre increments each cycle.
  - tick = en & ~done & (pre == PRESCALE-1). On a tick, pre returns to 0.
  - en = 0 freezes pre and q.
  - With PRESCALE = 1, tick = en & ~done.
- Terminal value: MODULUS-1 when up = 1; 0 when up = 0. at_term = (q == terminal).
- tc = tick & at_term. Combinational, no latency.
- Priority per edge: reset > load > tick > hold.
- Load:
  - q <= min(load_val, MODULUS-1). Out-of-range values clamp to MODULUS-1.
  - pre <= 0, done <= 0, wrap <= 0.
  - A tick in the same cycle is discarded.
- Tick, not at terminal: q <= q+1 (up) or q-1 (down).
- Tick at terminal, mode = 0: q <= 0 (up) or MODULUS-1 (down).
- Tick at terminal, mode = 1: q holds at terminal, done <= 1.
- wrap <= tc on every edge not overridden by reset/load. It is therefore a one-cycle pulse in the cycle after a terminal tick, in both modes.
- Once done = 1:
  - Ticks are suppressed; q and pre freeze.
  - Changing up or mode does not resume counting.
  - Only load or reset clears done.
- mode = 0 while done = 0: normal wrap behaviour.
- up may change on any cycle; the new direction applies from the next tick.
- A tick from an out-of-range q cannot occur, since load clamps.
- Reset mid-count discards prescaler progress and any pending wrap.

Test Plan:
- Reset/wrap, WIDTH=4, MODULUS=10, PRESCALE=1, en=1, up=1, mode=0: after reset q=0. q steps 0..9. tc=1 while q=9. Next edge q=0 and wrap=1 for exactly one cycle. done stays 0.
- Down wrap: load load_val=0, then up=0, en=1 → q: 0→9→8. tc=1 during the q=0 cycle, wrap pulse follows.
- Load clamp and priority: load=1 with load_val=12, en=1, tick pending → q=9, pre=0, no wrap. load_val=5 → q=5.
- Prescaler, PRESCALE=3, MODULUS=16, up=1: q increments on every 3rd enabled cycle. A 2-cycle en=0 gap mid-count delays the next step by exactly 2 cycles.
- One-shot, mode=1, MODULUS=10, up=1 from q=7: q 7→8→9, then holds 9. done=1 and wrap=1 one cycle. Further en=1 and toggling up leave q=9. load_val=3 → q=3, done=0.
- Reset mid-operation, PRESCALE=3: assert reset with q=6, pre=2, done=0 → next edge q=0, pre=0, wrap=0. First step occurs 3 enabled cycles after reset deasserts.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Purpose: parametrised synchronous up/down counter with modulus, prescaler, load, wrap/one-shot modes and flags.
// Latency: q, wrap and done update on the edge after a tick or load; tc is combinational in the tick cycle.
// Backpressure: none; en=0 freezes prescaler and count, and done=1 freezes everything until load or reset.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  // Prescaler is at least one bit wide so PRESCALE=1 still has a legal vector.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] load_clamped;
  logic             at_term;
  logic             tick;

  // Terminal value depends on direction; the tick fires on the last enabled prescaler cycle.
  always_comb begin
    term_val     = up ? MAX_VAL : '0;
    at_term      = (q_q == term_val);
    tick         = en & ~done_q & (pre_q == PRE_LAST);
    tc           = tick & at_term;
    load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  end

  // Next-state: load beats tick beats hold; wrap simply follows tc unless a load intervenes.
  always_comb begin
    q_d    = q_q;
    pre_d  = pre_q;
    wrap_d = tc;
    done_d = done_q;
    if (load) begin
      q_d    = load_clamped;
      pre_d  = '0;
      wrap_d = 1'b0;
      done_d = 1'b0;
    end else if (en && !done_q) begin
      if (tick) begin
        pre_d = '0;
        if (at_term) begin
          if (mode) begin
            // One-shot: hold at the terminal value and stop.
            done_d = 1'b1;
          end else begin
            q_d = up ? '0 : MAX_VAL;
          end
        end else begin
          q_d = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // State registers with synchronous reset, which also drops any pending wrap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign done = done_q;

endmodule
